ps2_key_controller: RTL
=======================

Name: ps2_key_controller

Overview:
Sequences the raw PS/2 byte stream from the keyboard interface (one strobe per received scan-code byte) into Pacman game commands. Tracks E0/F0 prefixes, maintains per-key held state, and queues turn requests in a small FIFO so a turn pressed early is applied at the next junction. Also emits single-cycle pause/start/escape pulses. Sits between the PS/2 interface and the game-logic FSM.

Parameters:
DEPTH, 4, turn-request FIFO depth (power of two, >=2)
TIMEOUT_CYCLES, 2500000, cycles a pending prefix may wait for its next byte (50 ms at 50 MHz)

Ports:
clock  input  1  system clock (50 MHz)
resetn  input  1  asynchronous active-low reset
ps2_key_data  input  8  received scan-code byte; valid only when ps2_key_pressed=1
ps2_key_pressed  input  1  one-cycle strobe per received byte
turn_valid  output  1  FIFO non-empty
turn_dir  output  2  head direction: 0 up, 1 right, 2 down, 3 left
turn_ready  input  1  consumer accepts head when turn_valid&turn_ready
held_dir  output  4  bit i = some key mapping to direction i currently held
pause_pulse  output  1  one cycle on make of P (0x4D)
start_pulse  output  1  one cycle on make of Enter (0x5A)
esc_pulse  output  1  one cycle on make of Esc (0x76)
overflow  output  1  sticky; set when a push hits a full FIFO; cleared only by reset

Behaviour:
- Reset (async, resetn=0): decoder state IDLE, timeout counter 0, all held bits 0, FIFO empty, turn_valid=0, turn_dir=0, held_dir=0, all pulses 0, overflow=0. Takes effect immediately, including mid-prefix and mid-handshake.
- Decoder FSM, advances only on ps2_key_pressed: IDLE: 0xE0->EXT, 0xF0->BRK, other->decode make(normal). EXT: 0xF0->EXT_BRK, other->decode make(extended), ->IDLE. BRK: decode break(normal), ->IDLE. EXT_BRK: decode break(extended), ->IDLE.
- Timeout: in EXT/BRK/EXT_BRK the counter increments each cycle without a strobe; when it reaches TIMEOUT_CYCLES-1, go to IDLE with no decode. Counter clears on every strobe and in IDLE.
- Key map: extended 0x75 up, 0x74 right, 0x72 down, 0x6B left; normal 0x1D(W) up, 0x23(D) right, 0x1B(S) down, 0x1C(A) left. Eight internal held bits, one per key. held_dir[i] = OR of its two keys. Unmapped codes are ignored.
- Make of direction key: if its held bit was 0, set it and push dir. If it was already 1 (typematic repeat), do nothing.
- Break: clear the key's held bit. Never push.
- Pause/start/esc: pulse registered 1 cycle after the decoding strobe. Repeats are suppressed by their own held bits; a break clears them. These keys are normal codes only; extended 0x5A (keypad Enter) is ignored.
- Push dedup: a push equal to the newest FIFO entry (FIFO non-empty) is dropped.
- FIFO full on push, no pop that cycle: overwrite the newest entry (newest intent wins) and set overflow. Simultaneous push and pop when full: the pop occurs and the push is appended normally, with no overflow. Push and pop when empty: the pushed value becomes visible next cycle.
- Latency: strobe at cycle N -> held_dir/FIFO/pulse visible at N+1. turn_dir is combinational from the head. A pop takes effect the next cycle.
- turn_dir holds its value while turn_valid=0 and turn_ready=0 (no X); the value is don't-care when turn_valid=0.

Decomposition:
- Package ps2_pkg: direction localparams (DIR_UP..DIR_LEFT), scan-code constants (PREFIX_EXT=0xE0, PREFIX_BRK=0xF0, key codes above), decoder state encodings.
- Sub-module ps2_turn_fifo: DEPTH x 2-bit circular FIFO with push/pop, newest-entry read, overwrite-newest-when-full, and count. The top level holds the FSM, timeout, and held/pulse logic.

Test Plan:
- Bytes E0,75 -> turn_valid=1, turn_dir=0, held_dir=0001. Then E0,F0,75 -> held_dir=0000, with no new push.
- Bytes 23 then 23,23,23 (typematic), turn_ready=0 -> exactly one entry (dir 1). Then F0,23,23 -> second push is dropped by dedup. Bytes 1B -> FIFO holds [1,2].
- turn_ready=0; pushes up, right, down, left, then W -> FIFO = [0,1,2,0] (left overwritten), overflow=1. Repeat with turn_ready=1 on the fifth push cycle -> no overwrite, overflow stays 0.
- Byte E0, then idle TIMEOUT_CYCLES (bench overrides to 16), then byte 75 -> decoded as normal 0x75, which is ignored. No push; held_dir=0.
- Byte 4D -> pause_pulse high for exactly 1 cycle. 4D again -> no pulse. F0,4D then 4D -> a second pulse.
- Deassert resetn between E0 and 75, and while FIFO holds 3 entries -> all outputs 0 immediately. After release, byte 75 alone produces no push.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 key controller: directions, scan codes, decoder states
// and the key-lookup helpers used by the decoder.
package ps2_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam logic [7:0] PREFIX_EXT    = 8'hE0;
  localparam logic [7:0] PREFIX_BRK    = 8'hF0;
  localparam logic [7:0] KEY_EXT_UP    = 8'h75;
  localparam logic [7:0] KEY_EXT_RIGHT = 8'h74;
  localparam logic [7:0] KEY_EXT_DOWN  = 8'h72;
  localparam logic [7:0] KEY_EXT_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_W         = 8'h1D;
  localparam logic [7:0] KEY_D         = 8'h23;
  localparam logic [7:0] KEY_S         = 8'h1B;
  localparam logic [7:0] KEY_A         = 8'h1C;
  localparam logic [7:0] KEY_P         = 8'h4D;
  localparam logic [7:0] KEY_ENTER     = 8'h5A;
  localparam logic [7:0] KEY_ESC       = 8'h76;

  localparam logic [1:0] SYS_PAUSE = 2'd0;
  localparam logic [1:0] SYS_START = 2'd1;
  localparam logic [1:0] SYS_ESC   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_t;

  // idx[2] selects the normal (WASD) bank, idx[1:0] is the direction
  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_sel_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } sys_sel_t;

  function automatic key_sel_t dir_key_sel(input logic [7:0] code, input logic ext);
    key_sel_t sel;
    sel.hit = 1'b1;
    sel.idx = 3'd0;
    if (ext) begin
      case (code)
        KEY_EXT_UP:    sel.idx = {1'b0, DIR_UP};
        KEY_EXT_RIGHT: sel.idx = {1'b0, DIR_RIGHT};
        KEY_EXT_DOWN:  sel.idx = {1'b0, DIR_DOWN};
        KEY_EXT_LEFT:  sel.idx = {1'b0, DIR_LEFT};
        default:       sel.hit = 1'b0;
      endcase
    end else begin
      case (code)
        KEY_W:   sel.idx = {1'b1, DIR_UP};
        KEY_D:   sel.idx = {1'b1, DIR_RIGHT};
        KEY_S:   sel.idx = {1'b1, DIR_DOWN};
        KEY_A:   sel.idx = {1'b1, DIR_LEFT};
        default: sel.hit = 1'b0;
      endcase
    end
    return sel;
  endfunction

  function automatic sys_sel_t sys_key_sel(input logic [7:0] code);
    sys_sel_t sel;
    sel.hit = 1'b1;
    sel.idx = 2'd0;
    case (code)
      KEY_P:     sel.idx = SYS_PAUSE;
      KEY_ENTER: sel.idx = SYS_START;
      KEY_ESC:   sel.idx = SYS_ESC;
      default:   sel.hit = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ps2_turn_fifo.sv
// Circular queue of 2-bit turn requests; when full and not popping, a push replaces
// the newest entry so the latest intent is kept.
module ps2_turn_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [1:0]                 push_data,
  input  logic                       pop,
  output logic [1:0]                 head,
  output logic [1:0]                 newest,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overwrite
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [1:0]    mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r, wr_ptr_r, newest_ptr_s;
  logic [CW-1:0] count_r;
  logic          full_s, pop_ok_s, append_s;

  assign newest_ptr_s = wr_ptr_r - 1'b1;
  assign full_s       = (count_r == CW'(DEPTH));
  assign pop_ok_s     = pop & (count_r != {CW{1'b0}});
  assign overwrite    = push & full_s & ~pop_ok_s;
  assign append_s     = push & ~overwrite;
  assign head         = mem_r[rd_ptr_r];
  assign newest       = mem_r[newest_ptr_s];
  assign count        = count_r;

  // Storage, pointers and occupancy
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= 2'd0;
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (pop_ok_s) rd_ptr_r <= rd_ptr_r + 1'b1;
      if (overwrite) begin
        mem_r[newest_ptr_s] <= push_data;
      end else if (append_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      case ({append_s, pop_ok_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_controller.sv
// Turns the PS/2 byte stream into Pacman commands: prefix decoding with timeout,
// per-key held state, a queued turn request stream and one-cycle control pulses.
module ps2_key_controller
  import ps2_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] ps2_key_data,
  input  logic       ps2_key_pressed,
  output logic       turn_valid,
  output logic [1:0] turn_dir,
  input  logic       turn_ready,
  output logic [3:0] held_dir,
  output logic       pause_pulse,
  output logic       start_pulse,
  output logic       esc_pulse,
  output logic       overflow
);
  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  dec_state_t    state_r, state_nxt_s;
  logic [TW-1:0] cnt_r, cnt_nxt_s;
  logic          decode_s, brk_s, ext_s;
  key_sel_t      dir_sel_s;
  sys_sel_t      sys_sel_s;
  logic [7:0]    held_r, held_nxt_s;
  logic [2:0]    sys_held_r, sys_held_nxt_s, pulse_r, pulse_nxt_s;
  logic          push_s, push_eff_s, pop_s, overwrite_s, overflow_r;
  logic [1:0]    push_dir_s, newest_s;
  logic [CW-1:0] fifo_count_s;

  // Prefix decoder next state and pending-prefix timeout
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = {TW{1'b0}};
    decode_s    = 1'b0;
    brk_s       = 1'b0;
    ext_s       = 1'b0;
    if (ps2_key_pressed) begin
      case (state_r)
        ST_IDLE: begin
          if (ps2_key_data == PREFIX_EXT) state_nxt_s = ST_EXT;
          else if (ps2_key_data == PREFIX_BRK) state_nxt_s = ST_BRK;
          else decode_s = 1'b1;
        end
        ST_EXT: begin
          if (ps2_key_data == PREFIX_BRK) begin
            state_nxt_s = ST_EXT_BRK;
          end else begin
            decode_s    = 1'b1;
            ext_s       = 1'b1;
            state_nxt_s = ST_IDLE;
          end
        end
        ST_BRK: begin
          decode_s    = 1'b1;
          brk_s       = 1'b1;
          state_nxt_s = ST_IDLE;
        end
        ST_EXT_BRK: begin
          decode_s    = 1'b1;
          brk_s       = 1'b1;
          ext_s       = 1'b1;
          state_nxt_s = ST_IDLE;
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end else if (state_r != ST_IDLE) begin
      if (cnt_r == TO_LAST) state_nxt_s = ST_IDLE;
      else cnt_nxt_s = cnt_r + 1'b1;
    end else begin
      cnt_nxt_s = {TW{1'b0}};
    end
  end

  assign dir_sel_s = dir_key_sel(ps2_key_data, ext_s);
  assign sys_sel_s = sys_key_sel(ps2_key_data);

  // Held-key bookkeeping; only a fresh make (not typematic repeat) pushes or pulses
  always_comb begin
    held_nxt_s     = held_r;
    sys_held_nxt_s = sys_held_r;
    pulse_nxt_s    = 3'b000;
    push_s         = 1'b0;
    push_dir_s     = dir_sel_s.idx[1:0];
    if (decode_s && dir_sel_s.hit) begin
      if (brk_s) begin
        held_nxt_s[dir_sel_s.idx] = 1'b0;
      end else if (!held_r[dir_sel_s.idx]) begin
        held_nxt_s[dir_sel_s.idx] = 1'b1;
        push_s                    = 1'b1;
      end else begin
        held_nxt_s = held_r;
      end
    end else if (decode_s && !ext_s && sys_sel_s.hit) begin
      if (brk_s) begin
        sys_held_nxt_s[sys_sel_s.idx] = 1'b0;
      end else if (!sys_held_r[sys_sel_s.idx]) begin
        sys_held_nxt_s[sys_sel_s.idx] = 1'b1;
        pulse_nxt_s[sys_sel_s.idx]    = 1'b1;
      end else begin
        sys_held_nxt_s = sys_held_r;
      end
    end else begin
      held_nxt_s = held_r;
    end
  end

  assign pop_s      = turn_valid & turn_ready;
  assign push_eff_s = push_s & ~(turn_valid & (newest_s == push_dir_s));

  ps2_turn_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (push_eff_s),
    .push_data (push_dir_s),
    .pop       (pop_s),
    .head      (turn_dir),
    .newest    (newest_s),
    .count     (fifo_count_s),
    .overwrite (overwrite_s)
  );

  assign turn_valid  = (fifo_count_s != {CW{1'b0}});
  assign held_dir    = held_r[3:0] | held_r[7:4];
  assign pause_pulse = pulse_r[0];
  assign start_pulse = pulse_r[1];
  assign esc_pulse   = pulse_r[2];
  assign overflow    = overflow_r;

  // Decoder, key-state, pulse and sticky overflow registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {TW{1'b0}};
      held_r     <= 8'h00;
      sys_held_r <= 3'b000;
      pulse_r    <= 3'b000;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      held_r     <= held_nxt_s;
      sys_held_r <= sys_held_nxt_s;
      pulse_r    <= pulse_nxt_s;
      overflow_r <= overflow_r | overwrite_s;
    end
  end

endmodule
